// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store unit and its lane-alignment helper.
package lsu_pkg;

    // RV32I load/store width and sign selectors
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam int unsigned RSP_TIMEOUT_DEFAULT = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } lsu_state_e;

    // Timer must hold 0..timeout; keep at least one bit when the timeout is disabled.
    function automatic int unsigned timer_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane steering for stores, extraction/extension for loads, and legality check.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_is_store,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_mask,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data,
    output logic        o_legal
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];

    // Alignment and funct3 legality; unsigned widths exist only for loads
    always_comb begin
        o_legal = 1'b0;
        case (i_funct3)
            F3_B:    o_legal = 1'b1;
            F3_H:    o_legal = ~i_addr_lo[0];
            F3_W:    o_legal = (i_addr_lo == 2'b00);
            F3_BU:   o_legal = ~i_is_store;
            F3_HU:   o_legal = ~i_is_store & ~i_addr_lo[0];
            default: o_legal = 1'b0;
        endcase
    end

    // Store lane enables and replicated write data; loads read the whole word
    always_comb begin
        o_mask  = 4'b1111;
        o_wdata = i_store_data;
        if (i_is_store) begin
            case (i_funct3)
                F3_B: begin
                    o_mask  = 4'b0001 << i_addr_lo;
                    o_wdata = {4{i_store_data[7:0]}};
                end
                F3_H: begin
                    o_mask  = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                    o_wdata = {2{i_store_data[15:0]}};
                end
                default: begin
                    o_mask  = 4'b1111;
                    o_wdata = i_store_data;
                end
            endcase
        end
    end

    // Load data extraction with sign or zero extension
    always_comb begin
        o_load_data = i_rdata;
        case (i_funct3)
            F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_load_data = {24'd0, w_byte};
            F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_load_data = {16'd0, w_half};
            default: o_load_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage running one load/store at a time against a
// variable-latency req/rsp data memory, stalling the pipeline while an access is in flight.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned RSP_TIMEOUT = RSP_TIMEOUT_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_store_data,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic [31:0] dmem_req_addr,
    output logic        dmem_req_wen,
    output logic [3:0]  dmem_req_mask,
    output logic [31:0] dmem_req_wdata,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rsp_rdata,
    output logic [31:0] mem_data_out,
    output logic        wb_valid,
    output logic        lsu_stall,
    output logic        misaligned,
    output logic        bus_err
);

    localparam int unsigned   TW         = timer_width(RSP_TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = (RSP_TIMEOUT == 0) ? '0 : TW'(RSP_TIMEOUT - 1);

    lsu_state_e    r_state;
    logic [31:0]   r_addr;
    logic [2:0]    r_funct3;
    logic          r_is_store;
    logic [3:0]    r_mask;
    logic [31:0]   r_wdata;
    logic [TW-1:0] r_timer;
    logic          r_req_valid;
    logic          r_wb_valid;
    logic          r_misaligned;
    logic          r_bus_err;
    logic [31:0]   r_mem_data;

    logic          w_idle;
    logic [2:0]    w_al_funct3;
    logic [1:0]    w_al_addr_lo;
    logic          w_al_is_store;
    logic [3:0]    w_al_mask;
    logic [31:0]   w_al_wdata;
    logic [31:0]   w_al_load_data;
    logic          w_al_legal;
    logic          w_op_legal;

    assign w_idle = (r_state == IDLE);

    // One aligner serves both phases: it checks the incoming op while idle and
    // extracts load data from the latched op while waiting for the response.
    assign w_al_funct3   = w_idle ? ex_funct3    : r_funct3;
    assign w_al_addr_lo  = w_idle ? ex_addr[1:0] : r_addr[1:0];
    assign w_al_is_store = w_idle ? ex_mem_write : r_is_store;

    // An op that is neither (or both) load and store is rejected like any illegal op.
    assign w_op_legal = w_al_legal & (ex_mem_read ^ ex_mem_write);

    lsu_align u_align (
        .i_funct3     (w_al_funct3),
        .i_addr_lo    (w_al_addr_lo),
        .i_is_store   (w_al_is_store),
        .i_store_data (ex_store_data),
        .i_rdata      (dmem_rsp_rdata),
        .o_mask       (w_al_mask),
        .o_wdata      (w_al_wdata),
        .o_load_data  (w_al_load_data),
        .o_legal      (w_al_legal)
    );

    // Access FSM with response timer; all outputs are registered here
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_funct3     <= '0;
            r_is_store   <= 1'b0;
            r_mask       <= '0;
            r_wdata      <= '0;
            r_timer      <= '0;
            r_req_valid  <= 1'b0;
            r_wb_valid   <= 1'b0;
            r_misaligned <= 1'b0;
            r_bus_err    <= 1'b0;
            r_mem_data   <= '0;
        end else begin
            r_wb_valid   <= 1'b0;
            r_misaligned <= 1'b0;
            r_bus_err    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (ex_valid) begin
                        if (w_op_legal) begin
                            r_addr      <= ex_addr;
                            r_funct3    <= ex_funct3;
                            r_is_store  <= ex_mem_write;
                            r_mask      <= w_al_mask;
                            r_wdata     <= w_al_wdata;
                            r_req_valid <= 1'b1;
                            r_state     <= REQ;
                        end else begin
                            r_misaligned <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (dmem_req_ready) begin
                        r_req_valid <= 1'b0;
                        r_timer     <= '0;
                        if (r_is_store) begin
                            r_wb_valid <= 1'b1;
                            r_state    <= IDLE;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // A response arriving on the expiry cycle takes priority over the timeout.
                    if (dmem_rsp_valid) begin
                        r_mem_data <= w_al_load_data;
                        r_wb_valid <= 1'b1;
                        r_state    <= IDLE;
                    end else if ((RSP_TIMEOUT != 0) && (r_timer == TIMER_LAST)) begin
                        r_bus_err <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: begin
                    r_req_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign ex_ready       = w_idle;
    assign lsu_stall      = ~w_idle;
    assign dmem_req_valid = r_req_valid;
    assign dmem_req_addr  = {r_addr[31:2], 2'b00};
    assign dmem_req_wen   = r_is_store;
    assign dmem_req_mask  = r_mask;
    assign dmem_req_wdata = r_wdata;
    assign mem_data_out   = r_mem_data;
    assign wb_valid       = r_wb_valid;
    assign misaligned     = r_misaligned;
    assign bus_err        = r_bus_err;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed scenarios plus randomized ops checked against a byte-level
// reference memory; the bench also plays the variable-latency data memory.
module tb_load_store_unit;

    localparam int unsigned TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_ready, ex_mem_read, ex_mem_write;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_store_data;
    logic        dmem_req_valid, dmem_req_ready, dmem_req_wen;
    logic [31:0] dmem_req_addr, dmem_req_wdata;
    logic [3:0]  dmem_req_mask;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rsp_rdata;
    logic [31:0] mem_data_out;
    logic        wb_valid, lsu_stall, misaligned, bus_err;

    always #5 clk = ~clk;

    load_store_unit #(.RSP_TIMEOUT(TIMEOUT)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_funct3      (ex_funct3),
        .ex_addr        (ex_addr),
        .ex_store_data  (ex_store_data),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_req_addr  (dmem_req_addr),
        .dmem_req_wen   (dmem_req_wen),
        .dmem_req_mask  (dmem_req_mask),
        .dmem_req_wdata (dmem_req_wdata),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rsp_rdata (dmem_rsp_rdata),
        .mem_data_out   (mem_data_out),
        .wb_valid       (wb_valid),
        .lsu_stall      (lsu_stall),
        .misaligned     (misaligned),
        .bus_err        (bus_err)
    );

    int checks = 0;
    int errors = 0;
    int n_wb = 0, n_mis = 0, n_berr = 0, n_req_cycles = 0;

    // Memory responder state
    int          ready_delay = 0, rsp_delay = 0, rdy_cnt = 0, rsp_cnt = 0;
    bit          rsp_en = 1'b1, rsp_pending = 1'b0, req_seen = 1'b0, req_unstable = 1'b0;
    logic [31:0] rsp_word, hold_addr, hold_wdata, last_addr, last_wdata;
    logic [3:0]  hold_mask, last_mask;
    logic        hold_wen, last_wen;

    logic [31:0] mem_w [1024];
    logic [7:0]  ref_b [4096];
    logic [31:0] exp_mdo;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int ref_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic bit ref_legal(input bit st, input logic [2:0] f3, input logic [31:0] a);
        int sz = ref_size(f3);
        if (sz == 0) return 1'b0;
        if (st && f3 >= 3'd4) return 1'b0;
        return (a % sz) == 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        int sz = ref_size(f3);
        logic [31:0] v = '0;
        for (int i = 0; i < sz; i++) v = v | (32'(ref_b[int'(a[11:0]) + i]) << (8 * i));
        if (f3 < 3'd4 && sz < 4 && v[8 * sz - 1]) v = v | (32'hFFFF_FFFF << (8 * sz));
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int sz = ref_size(f3);
        for (int i = 0; i < sz; i++) ref_b[int'(a[11:0]) + i] = d[8 * i +: 8];
    endtask

    task automatic poke(input logic [31:0] a, input logic [31:0] v);
        mem_w[a[11:2]] = v;
        for (int i = 0; i < 4; i++) ref_b[int'({a[11:2], 2'b00}) + i] = v[8 * i +: 8];
    endtask

    // Advance to the next falling edge, record pulses, and act as the data memory.
    task automatic step();
        @(negedge clk);
        if (wb_valid === 1'b1) n_wb++;
        if (misaligned === 1'b1) n_mis++;
        if (bus_err === 1'b1) n_berr++;
        if (dmem_req_valid === 1'b1) n_req_cycles++;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        if (rsp_pending) begin
            if (rsp_cnt == 0) begin
                dmem_rsp_valid = 1'b1;
                dmem_rsp_rdata = rsp_word;
                rsp_pending    = 1'b0;
            end else begin
                rsp_cnt--;
            end
        end
        if (dmem_req_valid === 1'b1) begin
            if (!req_seen) begin
                req_seen   = 1'b1;
                hold_addr  = dmem_req_addr;
                hold_wdata = dmem_req_wdata;
                hold_mask  = dmem_req_mask;
                hold_wen   = dmem_req_wen;
            end else if (hold_addr !== dmem_req_addr || hold_wdata !== dmem_req_wdata ||
                         hold_mask !== dmem_req_mask || hold_wen !== dmem_req_wen) begin
                req_unstable = 1'b1;
            end
            if (rdy_cnt >= ready_delay) begin
                dmem_req_ready = 1'b1;
                rdy_cnt    = 0;
                req_seen   = 1'b0;
                last_addr  = dmem_req_addr;
                last_wdata = dmem_req_wdata;
                last_mask  = dmem_req_mask;
                last_wen   = dmem_req_wen;
                if (dmem_req_wen) begin
                    for (int b = 0; b < 4; b++)
                        if (dmem_req_mask[b]) mem_w[dmem_req_addr[11:2]][8 * b +: 8] =
                            dmem_req_wdata[8 * b +: 8];
                end else if (rsp_en) begin
                    rsp_pending = 1'b1;
                    rsp_cnt     = rsp_delay;
                    rsp_word    = mem_w[dmem_req_addr[11:2]];
                end
            end else begin
                rdy_cnt++;
            end
        end
    endtask

    // Issue one op at a falling edge with the unit idle; outcome 1=wb, 2=misaligned,
    // 3=bus_err, 0=no completion within the cycle budget.
    task automatic run_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, output int outcome, output int lat,
                          output bit stall_ok);
        ex_valid      = 1'b1;
        ex_mem_write  = st;
        ex_mem_read   = ~st;
        ex_funct3     = f3;
        ex_addr       = a;
        ex_store_data = d;
        outcome  = 0;
        lat      = 0;
        stall_ok = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 1) ex_valid = 1'b0;
            if (wb_valid === 1'b1) outcome = 1;
            else if (misaligned === 1'b1) outcome = 2;
            else if (bus_err === 1'b1) outcome = 3;
            if (outcome != 0) begin
                lat = k;
                break;
            end
            if (lsu_stall !== 1'b1) stall_ok = 1'b0;
        end
    endtask

    int   oc, lat, wb0, mis0, req0, berr0;
    bit   sok;
    bit   st;
    logic [2:0]  f3;
    logic [31:0] a, d;
    bit          il_st [6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [2:0]  il_f3 [6]  = '{3'd4, 3'd3, 3'd1, 3'd5, 3'd6, 3'd2};
    logic [31:0] il_a  [6]  = '{32'h0, 32'h0, 32'h201, 32'h3, 32'h0, 32'h2};

    initial begin
        rst = 1'b1;
        ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
        ex_funct3 = '0; ex_addr = '0; ex_store_data = '0;
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rsp_rdata = '0;
        for (int w = 0; w < 1024; w++) poke(32'(w * 4), $urandom);
        repeat (3) step();
        rst = 1'b0;

        // Reset state
        check("rst_ex_ready", 32'(ex_ready), 32'd1);
        check("rst_stall", 32'(lsu_stall), 32'd0);
        check("rst_mdo", mem_data_out, 32'd0);
        check("rst_pulses", {29'd0, wb_valid, misaligned, bus_err}, 32'd0);
        check("rst_req_valid", 32'(dmem_req_valid), 32'd0);
        exp_mdo = 32'd0;

        // 1: LB 0x103, response two cycles after the request handshake
        poke(32'h100, 32'h80FF_1234);
        wb0 = n_wb; rsp_delay = 2;
        run_op(1'b0, 3'd0, 32'h103, 32'h0, oc, lat, sok);
        exp_mdo = 32'hFFFF_FF80;
        check("t1_outcome", 32'(oc), 32'd1);
        check("t1_data", mem_data_out, exp_mdo);
        check("t1_latency", 32'(lat), 32'd5);
        check("t1_stall", 32'(sok), 32'd1);
        check("t1_req", {last_addr[31:5], last_wen, last_mask}, {27'h8, 1'b0, 4'hF});
        step();
        check("t1_wb_once", 32'(n_wb - wb0), 32'd1);
        rsp_delay = 0;

        // 2: SH 0x202 with ready held off for three cycles
        ready_delay = 3; req_unstable = 1'b0;
        run_op(1'b1, 3'd1, 32'h202, 32'h0000_BEEF, oc, lat, sok);
        ref_store(3'd1, 32'h202, 32'h0000_BEEF);
        check("t2_outcome", 32'(oc), 32'd1);
        check("t2_latency", 32'(lat), 32'd5);
        check("t2_stable", 32'(req_unstable), 32'd0);
        check("t2_addr", last_addr, 32'h200);
        check("t2_mask", 32'(last_mask), 32'hC);
        check("t2_wdata", last_wdata, 32'hBEEF_BEEF);
        check("t2_wen", 32'(last_wen), 32'd1);
        ready_delay = 0;

        // 3: misaligned LW, then LHU from the upper half
        req0 = n_req_cycles;
        run_op(1'b0, 3'd2, 32'h106, 32'h0, oc, lat, sok);
        check("t3_mis_outcome", 32'(oc), 32'd2);
        check("t3_mis_latency", 32'(lat), 32'd1);
        check("t3_ex_ready", 32'(ex_ready), 32'd1);
        step();
        check("t3_no_req", 32'(n_req_cycles - req0), 32'd0);
        poke(32'h104, 32'hA5A5_0000);
        run_op(1'b0, 3'd5, 32'h106, 32'h0, oc, lat, sok);
        exp_mdo = 32'h0000_A5A5;
        check("t3_lhu", mem_data_out, exp_mdo);

        // Other rejected ops: bad store widths, reserved load widths, misaligned halves/words
        for (int i = 0; i < 6; i++) begin
            run_op(il_st[i], il_f3[i], il_a[i], 32'h0, oc, lat, sok);
            check("illegal_op", 32'(oc), 32'd2);
        end
        check("illegal_mdo", mem_data_out, exp_mdo);

        // 4: load with no response times out
        rsp_en = 1'b0; wb0 = n_wb;
        run_op(1'b0, 3'd2, 32'h100, 32'h0, oc, lat, sok);
        check("t4_outcome", 32'(oc), 32'd3);
        check("t4_latency", 32'(lat), 32'd6);
        check("t4_mdo", mem_data_out, exp_mdo);
        rsp_pending = 1'b1; rsp_cnt = 0; rsp_word = 32'h1234_5678;
        repeat (2) step();
        check("t4_late_mdo", mem_data_out, exp_mdo);
        check("t4_late_wb", 32'(n_wb - wb0), 32'd0);
        check("t4_idle", 32'(ex_ready), 32'd1);

        // 5: reset while waiting for a response
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
        ex_funct3 = 3'd2; ex_addr = 32'h100;
        step();
        ex_valid = 1'b0;
        step();
        check("t5_in_wait", 32'(lsu_stall), 32'd1);
        wb0 = n_wb; berr0 = n_berr;
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_mdo = 32'd0;
        check("t5_idle", 32'(ex_ready), 32'd1);
        check("t5_pulses", {29'd0, wb_valid, misaligned, bus_err}, 32'd0);
        check("t5_mdo", mem_data_out, exp_mdo);
        check("t5_req_valid", 32'(dmem_req_valid), 32'd0);
        repeat (6) step();
        check("t5_no_pulses", 32'(n_wb - wb0 + n_berr - berr0), 32'd0);
        rsp_en = 1'b1;
        poke(32'h000, 32'h0000_9900);
        run_op(1'b0, 3'd4, 32'h001, 32'h0, oc, lat, sok);
        exp_mdo = 32'h0000_0099;
        check("t5_lbu", mem_data_out, exp_mdo);

        // 6: back-to-back SW then LW to the same word with a single-cycle memory
        wb0 = n_wb; mis0 = n_mis; berr0 = n_berr;
        run_op(1'b1, 3'd2, 32'h300, 32'hDEAD_BEEF, oc, lat, sok);
        ref_store(3'd2, 32'h300, 32'hDEAD_BEEF);
        check("t6_sw_latency", 32'(lat), 32'd2);
        run_op(1'b0, 3'd2, 32'h300, 32'h0, oc, lat, sok);
        exp_mdo = 32'hDEAD_BEEF;
        check("t6_lw_latency", 32'(lat), 32'd3);
        check("t6_data", mem_data_out, exp_mdo);
        check("t6_wb_count", 32'(n_wb - wb0), 32'd2);
        check("t6_no_err", 32'(n_mis - mis0 + n_berr - berr0), 32'd0);

        // Randomized ops in a small window so loads revisit stored bytes
        req_unstable = 1'b0;
        for (int n = 0; n < 80; n++) begin
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = 32'h400 + $urandom_range(0, 31);
            d  = $urandom;
            ready_delay = $urandom_range(0, 2);
            rsp_delay   = $urandom_range(0, 2);
            run_op(st, f3, a, d, oc, lat, sok);
            if (!ref_legal(st, f3, a)) begin
                check("rand_illegal", 32'(oc), 32'd2);
            end else begin
                check("rand_complete", 32'(oc), 32'd1);
                if (st) ref_store(f3, a, d);
                else exp_mdo = ref_load(f3, a);
            end
            check("rand_mdo", mem_data_out, exp_mdo);
        end
        check("rand_stable", 32'(req_unstable), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
